// File: rtl/rv_mem_pkg.sv
// Shared definitions for the SPI memory arbiter: FSM encoding, port indices,
// field widths, the per-port request payload and a one-hot decode helper.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_PORTS   = 3;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NB_W        = 3;

    localparam int unsigned PORT_IFETCH = 0;
    localparam int unsigned PORT_DATA   = 1;
    localparam int unsigned PORT_DBG    = 2;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 512;

    // One request as presented to the SPI controller.
    typedef struct packed {
        logic              write;
        logic              is_data;
        logic [NB_W-1:0]   num_bytes;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Index of a 3-bit one-hot vector (bit1 of the index is port 2, bit0 is port 1).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        return {oh[2], oh[1]};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and controller-side signals of the memory arbiter.
// slave  : the arbiter's view (requests and controller status in, grants and
//          controller request fields out).
// master : the environment's view (requesters plus controller).
interface mem_arbiter_if;
    import rv_mem_pkg::*;

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        req_write;
    logic [NUM_PORTS-1:0]        req_is_data;
    logic [NUM_PORTS*NB_W-1:0]   req_num_bytes;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        gnt;
    logic [NUM_PORTS-1:0]        done;
    logic [NUM_PORTS-1:0]        err;
    logic [DATA_W-1:0]           rdata;
    logic                        busy;
    logic                        mem_start;
    logic                        mem_write;
    logic                        mem_is_data;
    logic [NB_W-1:0]             mem_num_bytes;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_done;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req, req_write, req_is_data, req_num_bytes, req_addr, req_wdata,
        input  mem_done, mem_rdata,
        output gnt, done, err, rdata, busy,
        output mem_start, mem_write, mem_is_data, mem_num_bytes, mem_addr, mem_wdata
    );

    modport master (
        output req, req_write, req_is_data, req_num_bytes, req_addr, req_wdata,
        output mem_done, mem_rdata,
        input  gnt, done, err, rdata, busy,
        input  mem_start, mem_write, mem_is_data, mem_num_bytes, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_priority_sel.sv
// Combinational 3-way round-robin picker.
// req    : pending request bits
// last   : index of the most recently served port; search starts at last+1
// winner : one-hot selected port (zero when nothing is requested)
// valid  : at least one request pending
module rr_priority_sel
    import rv_mem_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 valid
);

    assign valid = |req;

    // Unused last=3 searches from port 0, same as last=2.
    always_comb begin
        winner = '0;
        case (last)
            2'd0:    winner = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            2'd1:    winner = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default: winner = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI mem_controller between the
// instruction-fetch, load/store and debug ports. Each grant issues one
// start/done transaction guarded by a saturating watchdog, followed by a
// single GAP cycle with mem_start low.
// clk, rst_n : clock, synchronous active-low reset
// bus        : requester and controller signals (mem_arbiter_if.slave)
module mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e           state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     cur;
    logic [CNT_W-1:0]     wdog;
    mem_req_t             req_q;
    logic [NUM_PORTS-1:0] win_oh;
    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    mem_req_t             port_req [NUM_PORTS];

    // Unpack the per-port request fields.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_req[p] = '{
            write:     bus.req_write[p],
            is_data:   bus.req_is_data[p],
            num_bytes: bus.req_num_bytes[p*NB_W +: NB_W],
            addr:      bus.req_addr[p*ADDR_W +: ADDR_W],
            wdata:     bus.req_wdata[p*DATA_W +: DATA_W]
        };
    end

    rr_priority_sel u_sel (
        .req    (bus.req),
        .last   (last),
        .winner (win_oh),
        .valid  (win_valid)
    );

    assign win_idx = onehot_to_idx(win_oh);

    assign bus.mem_write     = req_q.write;
    assign bus.mem_is_data   = req_q.is_data;
    assign bus.mem_num_bytes = req_q.num_bytes;
    assign bus.mem_addr      = req_q.addr;
    assign bus.mem_wdata     = req_q.wdata;

    // Arbitration / sequencing FSM; done and err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last          <= IDX_W'(PORT_DBG);
            cur           <= '0;
            wdog          <= '0;
            req_q         <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= '0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.mem_start <= 1'b0;
        end else begin
            bus.done <= '0;
            bus.err  <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        req_q         <= port_req[win_idx];
                        cur           <= win_idx;
                        bus.gnt       <= win_oh;
                        bus.mem_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        wdog          <= '0;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Completion wins over a timeout expiring in the same cycle.
                    if (bus.mem_done) begin
                        bus.rdata     <= bus.mem_rdata;
                        bus.done      <= bus.gnt;
                        bus.gnt       <= '0;
                        bus.mem_start <= 1'b0;
                        last          <= cur;
                        state         <= ST_GAP;
                    end else if (wdog == WDOG_LAST) begin
                        bus.done      <= bus.gnt;
                        bus.err       <= bus.gnt;
                        bus.gnt       <= '0;
                        bus.mem_start <= 1'b0;
                        last          <= cur;
                        state         <= ST_GAP;
                    end else if (wdog != '1) begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
